lcd_nibble_writer: RTL and testbench
====================================

// Module: lcd_nibble_writer
// PURPOSE
//  Output stage downstream of MiniAlu: takes byte-wide commands/characters from the core
//  and drives a 4-bit HD44780-style character LCD (write-only).
//  Each accepted byte is sent as two nibbles (high first), each framed by a timed E strobe,
//  followed by the controller's busy wait. Replaces polling the busy flag; RW is tied low.
// PARAMETERS
//  SETUP_CYC      2      cycles data/RS stable before E rises (per nibble)
//  E_HIGH_CYC     12     cycles E held high (per nibble)
//  NIB_GAP_CYC    50     cycles E low between high and low nibble
//  CMD_WAIT_CYC   2000   post-byte wait, normal commands/data (40 us @ 50 MHz)
//  LONG_WAIT_CYC  82000  post-byte wait for clear (8'h01) / home (8'h02) commands
// PORTS
//  Clock       in   1  system clock, all logic on rising edge
//  Reset       in   1  asynchronous, active-high reset
//  iData       in   8  byte to write (command if iRS=0, character if iRS=1)
//  iRS         in   1  register select for iData
//  iValid      in   1  request; transfer occurs on cycle with iValid && oReady
//  oReady      out  1  1 only in IDLE; block can accept a byte this cycle
//  oLCD_E      out  1  LCD enable strobe
//  oLCD_RS     out  1  LCD register select
//  oLCD_RW     out  1  LCD read/write, constant 0
//  oLCD_D      out  4  LCD data nibble (D7..D4)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, oReady=1 after release, oLCD_E=0, oLCD_RS=0,
//    oLCD_D=4'h0, counter=0, latched byte cleared. Reset mid-strobe drops E at once.
//  - All LCD outputs registered; no combinational path from inputs to outputs.
//  - Accept: in IDLE with iValid=1 -> latch iData/iRS, oReady=0 from next cycle.
//    iValid while oReady=0 is ignored (not queued); requester must hold until accepted.
//  - FSM (one counter, loaded on entry, state advances when counter reaches 0):
//    IDLE     -> HI_SETUP on accept
//    HI_SETUP D=data[7:4], RS=latched, E=0, SETUP_CYC cycles -> HI_PULSE
//    HI_PULSE E=1, E_HIGH_CYC cycles -> HI_GAP
//    HI_GAP   E=0, D held, NIB_GAP_CYC cycles -> LO_SETUP
//    LO_SETUP D=data[3:0], E=0, SETUP_CYC cycles -> LO_PULSE
//    LO_PULSE E=1, E_HIGH_CYC cycles -> WAIT
//    WAIT     E=0, D/RS held; LONG_WAIT_CYC if RS=0 and data in {8'h01,8'h02}
//             else CMD_WAIT_CYC -> IDLE
//  - Busy length after accept = 2*SETUP+2*E_HIGH+NIB_GAP+WAIT cycles; oReady=1 on the
//    following cycle; back-to-back accept allowed on that first ready cycle.
//  - Counter width = $clog2(max parameter + 1); every parameter >= 1, 0 is illegal.
//  - D/RS never change while E=1; E never high outside *_PULSE states.
//  - Leaving WAIT, D/RS keep last values until next accept (no glitch to 0).
// STRUCTURE
//  - lcd_pkg: FSM state encoding, LCD_CMD_CLEAR=8'h01, LCD_CMD_HOME=8'h02.
//  - One sub-module: lcd_delay_counter (load value, decrement, zero flag).
//  - Top: FSM + latch register + output registers.
// TESTING  (sim params SETUP=2, E_HIGH=3, NIB_GAP=4, CMD_WAIT=5, LONG_WAIT=9)
//  1 Reset held 50 ns then released -> E=0, RS=0, D=0, RW=0, oReady=1.
//  2 iData=8'hA5, iRS=1 for one cycle -> D=4'hA, 2 cyc E=0, 3 cyc E=1, 4 gap, D=4'h5,
//    2 cyc, 3 cyc E=1, 5 wait; oReady=0 for 19 cycles, then 1.
//  3 iData=8'h01, iRS=0 -> identical strobes, wait 9; oReady=0 for 23 cycles.
//  4 iData=8'h01, iRS=1 (character) -> normal wait 5 (19 cycles busy).
//  5 Assert Reset during HI_PULSE -> E=0 same timestep, IDLE, byte discarded.
//  6 iValid held high across two bytes (8'h28 then 8'h0C) -> second accepted on first
//    ready cycle; exactly 4 E pulses total, D/RS stable whenever E=1 (assertion).

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the 4-bit character LCD writer.
//   lcd_state_t      FSM state encoding for lcd_nibble_writer
//   LCD_CMD_CLEAR    clear-display command byte
//   LCD_CMD_HOME     return-home command byte
//   needs_long_wait  1 when a latched byte is a slow (clear/home) command
//   max_of           integer maximum, used to size the delay counter
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI_SETUP,
    ST_HI_PULSE,
    ST_HI_GAP,
    ST_LO_SETUP,
    ST_LO_PULSE,
    ST_WAIT
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Clear and home are only slow when sent as commands (RS=0); the same
  // byte values written as characters take the normal wait.
  function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: down-counter shared by all timed FSM states.
//   clk       in   system clock
//   rst       in   asynchronous active-high reset (count cleared)
//   load      in   load load_val this cycle (takes priority over decrement)
//   load_val  in   value to load; a state lasting N cycles loads N-1
//   zero      out  count is zero; the owning state ends this cycle
module lcd_delay_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: writes bytes to a 4-bit HD44780-style LCD (write-only).
// Each accepted byte goes out as high then low nibble, each framed by a timed
// E strobe, followed by a fixed controller busy wait (no busy-flag polling).
//   Clock    in   system clock, rising edge
//   Reset    in   asynchronous active-high reset
//   iData    in   byte to write (command if iRS=0, character if iRS=1)
//   iRS      in   register select for iData
//   iValid   in   request; transfer on a cycle with iValid && oReady
//   oReady   out  high only while idle
//   oLCD_E   out  LCD enable strobe
//   oLCD_RS  out  LCD register select
//   oLCD_RW  out  LCD read/write, tied low
//   oLCD_D   out  LCD data nibble (D7..D4)
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC     = 2,
  parameter int E_HIGH_CYC    = 12,
  parameter int NIB_GAP_CYC   = 50,
  parameter int CMD_WAIT_CYC  = 2000,
  parameter int LONG_WAIT_CYC = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_D
);

  localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYC, E_HIGH_CYC),
                                         max_of(NIB_GAP_CYC, CMD_WAIT_CYC)),
                                  LONG_WAIT_CYC);
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  // A state lasting N cycles loads N-1 on entry and leaves when the count hits 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(NIB_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYC - 1);

  lcd_state_t       state_q, state_d;
  logic [7:0]       data_q;
  logic             rs_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             accept;
  logic             lo_load;

  lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
    .clk      (Clock),
    .rst      (Reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    accept   = 1'b0;
    lo_load  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iValid) begin
          accept   = 1'b1;
          state_d  = ST_HI_SETUP;
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
        end
      end
      ST_HI_SETUP: begin
        if (cnt_zero) begin
          state_d  = ST_HI_PULSE;
          cnt_load = 1'b1;
          cnt_val  = E_LD;
        end
      end
      ST_HI_PULSE: begin
        if (cnt_zero) begin
          state_d  = ST_HI_GAP;
          cnt_load = 1'b1;
          cnt_val  = GAP_LD;
        end
      end
      ST_HI_GAP: begin
        if (cnt_zero) begin
          state_d  = ST_LO_SETUP;
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
          lo_load  = 1'b1;
        end
      end
      ST_LO_SETUP: begin
        if (cnt_zero) begin
          state_d  = ST_LO_PULSE;
          cnt_load = 1'b1;
          cnt_val  = E_LD;
        end
      end
      ST_LO_PULSE: begin
        if (cnt_zero) begin
          state_d  = ST_WAIT;
          cnt_load = 1'b1;
          cnt_val  = needs_long_wait(rs_q, data_q) ? LONG_LD : CMD_LD;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up exactly with
  // the state register. D/RS only change on entry to a setup state, where E
  // is already low, so they are stable for the whole strobe and are simply
  // held after the wait until the next accept.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rs_q    <= 1'b0;
      oReady  <= 1'b1;
      oLCD_E  <= 1'b0;
      oLCD_RS <= 1'b0;
      oLCD_D  <= '0;
    end else begin
      state_q <= state_d;
      oReady  <= (state_d == ST_IDLE);
      oLCD_E  <= (state_d == ST_HI_PULSE) || (state_d == ST_LO_PULSE);
      if (accept) begin
        data_q  <= iData;
        rs_q    <= iRS;
        oLCD_D  <= iData[7:4];
        oLCD_RS <= iRS;
      end else if (lo_load) begin
        oLCD_D  <= data_q[3:0];
      end
    end
  end

  assign oLCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
module tb_lcd_nibble_writer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] iData;
  logic       iRS;
  logic       iValid;
  logic       oReady;
  logic       oLCD_E;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic [3:0] oLCD_D;

  int vectors     = 0;
  int miscompares = 0;
  int stab_err    = 0;

  lcd_nibble_writer #(
    .SETUP_CYC     (2),
    .E_HIGH_CYC    (3),
    .NIB_GAP_CYC   (4),
    .CMD_WAIT_CYC  (5),
    .LONG_WAIT_CYC (9)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iData   (iData),
    .iRS     (iRS),
    .iValid  (iValid),
    .oReady  (oReady),
    .oLCD_E  (oLCD_E),
    .oLCD_RS (oLCD_RS),
    .oLCD_RW (oLCD_RW),
    .oLCD_D  (oLCD_D)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         busy;
    logic [3:0] hi;
    logic [3:0] lo;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // D/RS must not move while E stays high.
  logic       mon_e;
  logic [3:0] mon_d;
  logic       mon_rs;
  always @(negedge Clock) begin
    if (Reset) begin
      mon_e <= 1'b0;
    end else begin
      if (oLCD_E && mon_e && ((oLCD_D != mon_d) || (oLCD_RS != mon_rs)))
        stab_err <= stab_err + 1;
      mon_e  <= oLCD_E;
      mon_d  <= oLCD_D;
      mon_rs <= oLCD_RS;
    end
  end

  // Send one byte and trace 40 cycles, sampled on falling edges.
  // k=0 is the first falling edge after the accepting rising edge.
  task automatic run_byte(input logic [7:0] d, input logic rs,
                          output int busy, output int rise1, output int rise2,
                          output int w1, output int w2,
                          output logic [3:0] n1, output logic [3:0] n2,
                          output logic rs_seen, output int npulse);
    logic prev_e;
    bit   rdy_seen;
    @(negedge Clock);
    iData = d; iRS = rs; iValid = 1'b1;
    @(negedge Clock);
    iValid = 1'b0;
    busy = 0; rise1 = -1; rise2 = -1; w1 = 0; w2 = 0;
    n1 = 4'hx; n2 = 4'hx; rs_seen = 1'bx; npulse = 0;
    prev_e = 1'b0; rdy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (oReady) rdy_seen = 1;
      else if (!rdy_seen) busy++;
      if (oLCD_E && !prev_e) begin
        npulse++;
        if (npulse == 1) begin rise1 = k; n1 = oLCD_D; rs_seen = oLCD_RS; end
        else if (npulse == 2) begin rise2 = k; n2 = oLCD_D; end
      end
      if (oLCD_E) begin
        if (npulse == 1) w1++;
        else if (npulse == 2) w2++;
      end
      prev_e = oLCD_E;
      if (k < 39) @(negedge Clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int busy, r1, r2, w1, w2, np;
    logic [3:0] n1, n2;
    logic rs_s;

    //                data    rs    busy hi    lo
    vecs[0] = '{8'hA5, 1'b1, 19, 4'hA, 4'h5};
    vecs[1] = '{8'h01, 1'b0, 23, 4'h0, 4'h1};
    vecs[2] = '{8'h01, 1'b1, 19, 4'h0, 4'h1};
    vecs[3] = '{8'h02, 1'b0, 23, 4'h0, 4'h2};
    vecs[4] = '{8'h02, 1'b1, 19, 4'h0, 4'h2};
    vecs[5] = '{8'h03, 1'b0, 19, 4'h0, 4'h3};
    vecs[6] = '{8'h00, 1'b0, 19, 4'h0, 4'h0};
    vecs[7] = '{8'h3C, 1'b1, 19, 4'h3, 4'hC};

    iData = 8'h00; iRS = 1'b0; iValid = 1'b0;
    Reset = 1'b1;
    #50 Reset = 1'b0;
    #1;
    check("reset_e",     oLCD_E,  0);
    check("reset_rs",    oLCD_RS, 0);
    check("reset_d",     oLCD_D,  0);
    check("reset_rw",    oLCD_RW, 0);
    check("reset_ready", oReady,  1);

    foreach (vecs[i]) begin
      run_byte(vecs[i].data, vecs[i].rs, busy, r1, r2, w1, w2, n1, n2, rs_s, np);
      check($sformatf("v%0d_busy", i),    busy, vecs[i].busy);
      check($sformatf("v%0d_pulses", i),  np,   2);
      check($sformatf("v%0d_rise_hi", i), r1,   2);
      check($sformatf("v%0d_rise_lo", i), r2,   11);
      check($sformatf("v%0d_w_hi", i),    w1,   3);
      check($sformatf("v%0d_w_lo", i),    w2,   3);
      check($sformatf("v%0d_d_hi", i),    n1,   vecs[i].hi);
      check($sformatf("v%0d_d_lo", i),    n2,   vecs[i].lo);
      check($sformatf("v%0d_rs", i),      rs_s, vecs[i].rs);
      check($sformatf("v%0d_d_held", i),  oLCD_D,  vecs[i].lo);
      check($sformatf("v%0d_rs_held", i), oLCD_RS, vecs[i].rs);
      check($sformatf("v%0d_ready", i),   oReady,  1);
    end

    // Reset during the high-nibble strobe.
    begin
      int e_after;
      @(negedge Clock);
      iData = 8'h41; iRS = 1'b1; iValid = 1'b1;
      @(negedge Clock);
      iValid = 1'b0;
      repeat (3) @(negedge Clock);
      check("midrst_e_before", oLCD_E, 1);
      #2 Reset = 1'b1;
      #1;
      check("midrst_e_drop", oLCD_E,  0);
      check("midrst_d",      oLCD_D,  0);
      check("midrst_rs",     oLCD_RS, 0);
      @(negedge Clock);
      Reset = 1'b0;
      e_after = 0;
      for (int k = 0; k < 30; k++) begin
        if (oLCD_E) e_after++;
        @(negedge Clock);
      end
      check("midrst_no_resume", e_after, 0);
      check("midrst_ready",     oReady,  1);
    end

    // iValid held across two bytes: second accepted on first ready cycle.
    begin
      int acc;
      int acc_cyc [2];
      int pulses;
      logic [3:0] nibs [4];
      logic [3:0] rss;
      logic prev;
      acc = 0; pulses = 0; prev = 1'b0;
      acc_cyc[0] = -1; acc_cyc[1] = -1;
      rss = 4'h0;
      @(negedge Clock);
      iData = 8'h28; iRS = 1'b0; iValid = 1'b1;
      for (int k = 0; k < 80; k++) begin
        if (oLCD_E && !prev) begin
          if (pulses < 4) begin
            nibs[pulses] = oLCD_D;
            rss[pulses]  = oLCD_RS;
          end
          pulses++;
        end
        prev = oLCD_E;
        if (oReady && iValid && acc < 2) begin
          acc_cyc[acc] = k;
          acc++;
        end
        @(posedge Clock);
        #1;
        if (acc == 1) iData = 8'h0C;
        if (acc == 2) iValid = 1'b0;
        @(negedge Clock);
      end
      iValid = 1'b0;
      check("b2b_accepts", acc, 2);
      check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 20);
      check("b2b_pulses",  pulses, 4);
      check("b2b_n0", nibs[0], 4'h2);
      check("b2b_n1", nibs[1], 4'h8);
      check("b2b_n2", nibs[2], 4'h0);
      check("b2b_n3", nibs[3], 4'hC);
      check("b2b_rs", rss, 4'h0);
    end

    check("d_rs_stable_under_e", stab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
